// File: rtl/fsm_pkg.sv
// Shared state encoding and default sizing for the counter and its sequence checker.
package fsm_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SYNC = 2'd1;
    localparam logic [1:0] LOCK = 2'd2;

    localparam int unsigned DEFAULT_CNT_W       = 3;
    localparam int unsigned DEFAULT_LOCK_CYCLES = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset and clear.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] Max = '1;
    localparam logic [W-1:0] One = W'(1);

    logic [W-1:0] q_q, q_d;

    // A clear coinciding with an increment leaves the count at one, not zero.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = inc ? One : '0;
        end else if (inc && (q_q != Max)) begin
            q_d = q_q + One;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/count_sequence_checker.sv
// Monitors a free-running counter: acquires lock after a run of +1 steps, then
// counts wraps and sequence errors.
module count_sequence_checker
    import fsm_pkg::*;
#(
    parameter int unsigned CNT_W       = DEFAULT_CNT_W,
    parameter int unsigned LOCK_CYCLES = DEFAULT_LOCK_CYCLES,
    parameter int unsigned ERR_W       = 8,
    parameter int unsigned WRAP_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [CNT_W-1:0]  count_in,
    input  logic              clr_err,
    output logic              locked,
    output logic              err,
    output logic [ERR_W-1:0]  err_count,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              wrap_pulse
);

    localparam int unsigned      MatchW     = 4;
    localparam logic [MatchW-1:0] LockTarget = MatchW'(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax     = '1;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  prev_q, prev_d;
    logic [MatchW-1:0] match_q, match_d;
    logic              locked_q, locked_d;
    logic              err_q, err_d;
    logic              wrap_pulse_q;
    logic              err_inc, wrap_inc;
    logic [CNT_W-1:0]  expected;
    logic              step_ok;

    assign expected = prev_q + CntOne;
    assign step_ok  = (count_in == expected);

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        match_d  = match_q;
        err_d    = clr_err ? 1'b0 : err_q;
        err_inc  = 1'b0;
        wrap_inc = 1'b0;

        if (!enable) begin
            state_d = IDLE;
        end else begin
            prev_d = count_in;
            case (state_q)
                IDLE: begin
                    match_d = '0;
                    state_d = SYNC;
                end
                SYNC: begin
                    if (step_ok) begin
                        if (match_q + 4'd1 == LockTarget) begin
                            state_d = LOCK;
                            match_d = '0;
                        end else begin
                            match_d = match_q + 4'd1;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCK: begin
                    if (step_ok) begin
                        wrap_inc = (prev_q == CntMax) && (count_in == '0);
                    end else begin
                        err_d   = 1'b1;
                        err_inc = 1'b1;
                        match_d = '0;
                        state_d = SYNC;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        locked_d = (state_d == LOCK);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            prev_q       <= '0;
            match_q      <= '0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            wrap_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            match_q      <= match_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            wrap_pulse_q <= wrap_inc;
        end
    end

    sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (err_inc),
        .clr (clr_err),
        .q   (err_count)
    );

    sat_counter #(
        .W (WRAP_W)
    ) u_wrap_cnt (
        .clk (clk),
        .rst (rst),
        .inc (wrap_inc),
        .clr (1'b0),
        .q   (wrap_count)
    );

    assign locked     = locked_q;
    assign err        = err_q;
    assign wrap_pulse = wrap_pulse_q;

endmodule
